hazard_tracker: RTL
===================

HAZARD_TRACKER -- requirements
Module: hazard_tracker

Interface
REQ-001 Parameter NUM_STAGES, default 3, in-flight stages after decode (0=EXE, 1=MEM, 2=WB).
REQ-002 Parameter REG_ADDR_W, default 5, register address width.
REQ-003 Parameter FWD_EN, default 1, 1 = resolve hazards by forwarding where possible, 0 = stall on every hazard.
REQ-004 Parameter FLUSH_DEPTH, default 1, number of youngest stages cleared by a flush (0..NUM_STAGES).
REQ-005 Parameter SEL_W, default $clog2(NUM_STAGES+1), forward-select width.
REQ-006 clk_i  in  1  clock; all state updates on rising edge.
REQ-007 rstn_i  in  1  reset, asynchronous, active-low.
REQ-008 issue_valid_i  in  1  decode holds a valid instruction.
REQ-009 issue_rd_i  in  REG_ADDR_W  destination register of the decode instruction.
REQ-010 issue_we_i  in  1  decode instruction writes rd.
REQ-011 issue_rdy_stage_i  in  SEL_W  first stage index at which its result is forwardable (EXE=0, load=1).
REQ-012 rs1_i, rs2_i  in  REG_ADDR_W each  decode source registers.
REQ-013 rs1_use_i, rs2_use_i  in  1 each  source is actually read.
REQ-014 exe_stall_i  in  1  multi-cycle EXE unit busy; stage 0 must hold.
REQ-015 flush_i  in  1  taken branch; kill decode and the youngest FLUSH_DEPTH stages.
REQ-016 stall_o  out  1  decode must hold.
REQ-017 issue_fire_o  out  1  decode instruction enters stage 0 this cycle.
REQ-018 fwd_rs1_sel_o, fwd_rs2_sel_o  out  SEL_W each  0 = regfile, k+1 = forward from stage k.
REQ-019 stage_valid_o  out  NUM_STAGES  per-stage valid.
REQ-020 stall_cnt_o  out  32  count of cycles with stall_o=1, saturating at 32'hFFFF_FFFF.

Function
REQ-021 Each stage entry holds {valid, rd, we, rdy_stage}; stage_valid_o[k] = entry[k].valid.
REQ-022 Match on stage k for rsX: rsX_use_i & rsX_i != 0 & entry[k].valid & entry[k].we & entry[k].rd == rsX_i; x0 never matches.
REQ-023 The youngest matching stage (lowest k) governs each source; older matches are ignored.
REQ-024 FWD_EN=1: hazard if governing k < entry[k].rdy_stage; otherwise fwd_sel = k+1.
REQ-025 FWD_EN=0: any match is a hazard; fwd_sel always 0.
REQ-026 No match: fwd_sel = 0; fwd_sel outputs are combinational and meaningful only when issue_fire_o=1.
REQ-027 stall_o = (hazard on rs1 or rs2) | exe_stall_i, combinational; flush_i does not assert stall_o.
REQ-028 issue_fire_o = issue_valid_i & ~stall_o & ~flush_i.
REQ-029 Normal advance: entry[0] <= issue fields if issue_fire_o else bubble; entry[k] <= entry[k-1] for k>=1.
REQ-030 exe_stall_i=1 and flush_i=0: entry[0] holds, entry[1] <= bubble, entry[k>=2] shift normally.
REQ-031 flush_i=1: after the advance of REQ-029, entry[j].valid <= 0 for all j < FLUSH_DEPTH; flush_i overrides exe_stall_i (stage 0 advances).
REQ-032 FLUSH_DEPTH=0: flush kills only the decode issue.
REQ-033 Entry at stage NUM_STAGES-1 retires unconditionally next cycle.
REQ-034 stall_cnt_o increments by 1 each cycle stall_o=1 and holds at all-ones.

Reset
REQ-035 rstn_i low: all entry valid/we bits 0, rd/rdy_stage 0, stall_cnt_o 0, asynchronously and regardless of clock.
REQ-036 Consequently, during and after reset with no issue: stall_o = exe_stall_i, stage_valid_o = 0, fwd selects 0.
REQ-037 Reset asserted mid-stall discards all in-flight entries; no state survives.

Verification
REQ-038 Defaults; issue rd=5 we=1 rdy=0, next cycle rs1=5 use=1 -> stall_o=0, fwd_rs1_sel_o=1, issue_fire_o=1.
REQ-039 Load rd=7 rdy=1, next cycle rs2=7 -> stall_o=1 one cycle, then fwd_rs2_sel_o=2 with fire; stall_cnt_o=1.
REQ-040 FWD_EN=0; rd=3 issued, next rs1=3 -> stall_o=1 for exactly 3 cycles, then fire with fwd_rs1_sel_o=0.
REQ-041 Two writers rd=4 in stages 0 and 1, rs1=4 -> fwd_rs1_sel_o=1 (youngest); rs1=0 with rd=0 writer -> no stall, sel 0.
REQ-042 exe_stall_i=1 two cycles with valid entry in stage 0 -> stage_valid_o=3'b001 hold, bubble into stage 1, stall_o=1.
REQ-043 flush_i with issue_valid_i=1, FLUSH_DEPTH=1 -> issue_fire_o=0, next stage_valid_o[0]=0; reset mid-run -> stage_valid_o=0, stall_cnt_o=0.

Source files
------------

// File: rtl/hazard_tracker_if.sv
// Decode-side bus for the hazard tracker: issue fields and source operands in,
// stall / fire / forward selects and pipeline status out.
interface hazard_tracker_if #(
  parameter int NUM_STAGES = 3,
  parameter int REG_ADDR_W = 5,
  parameter int SEL_W      = $clog2(NUM_STAGES + 1)
) ();

  logic                  issue_valid_i;
  logic [REG_ADDR_W-1:0] issue_rd_i;
  logic                  issue_we_i;
  logic [SEL_W-1:0]      issue_rdy_stage_i;
  logic [REG_ADDR_W-1:0] rs1_i;
  logic [REG_ADDR_W-1:0] rs2_i;
  logic                  rs1_use_i;
  logic                  rs2_use_i;
  logic                  exe_stall_i;
  logic                  flush_i;
  logic                  stall_o;
  logic                  issue_fire_o;
  logic [SEL_W-1:0]      fwd_rs1_sel_o;
  logic [SEL_W-1:0]      fwd_rs2_sel_o;
  logic [NUM_STAGES-1:0] stage_valid_o;
  logic [31:0]           stall_cnt_o;

  // Decode stage side
  modport master (
    output issue_valid_i, issue_rd_i, issue_we_i, issue_rdy_stage_i,
    output rs1_i, rs2_i, rs1_use_i, rs2_use_i, exe_stall_i, flush_i,
    input  stall_o, issue_fire_o, fwd_rs1_sel_o, fwd_rs2_sel_o,
    input  stage_valid_o, stall_cnt_o
  );

  // Hazard tracker side
  modport slave (
    input  issue_valid_i, issue_rd_i, issue_we_i, issue_rdy_stage_i,
    input  rs1_i, rs2_i, rs1_use_i, rs2_use_i, exe_stall_i, flush_i,
    output stall_o, issue_fire_o, fwd_rs1_sel_o, fwd_rs2_sel_o,
    output stage_valid_o, stall_cnt_o
  );

endinterface

// File: rtl/hazard_tracker.sv
// Scoreboard of in-flight destination registers behind decode. Detects RAW
// hazards for the two decode sources, picks a forwarding stage where the
// producer's result is already available, and otherwise stalls decode.
module hazard_tracker #(
  parameter int NUM_STAGES  = 3,
  parameter int REG_ADDR_W  = 5,
  parameter int FWD_EN      = 1,
  parameter int FLUSH_DEPTH = 1,
  parameter int SEL_W       = $clog2(NUM_STAGES + 1)
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  hazard_tracker_if.slave bus
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  we;
    logic [SEL_W-1:0]      rdy_stage;
  } entry_t;

  localparam entry_t BUBBLE = '0;

  entry_t                entry_r     [NUM_STAGES];
  entry_t                entry_nxt_s [NUM_STAGES];
  entry_t                issue_entry_s;
  logic [REG_ADDR_W-1:0] src_rs_s    [2];
  logic                  src_use_s   [2];
  logic                  src_haz_s   [2];
  logic [SEL_W-1:0]      src_sel_s   [2];
  logic                  stall_s;
  logic                  fire_s;
  logic                  hold_s;
  logic [31:0]           stall_cnt_r;

  // Gather both decode sources so they share one resolution loop
  always_comb begin
    src_rs_s[0]  = bus.rs1_i;
    src_rs_s[1]  = bus.rs2_i;
    src_use_s[0] = bus.rs1_use_i;
    src_use_s[1] = bus.rs2_use_i;
  end

  // Per source: the youngest matching stage decides forward-vs-stall
  always_comb begin
    logic             haz_v;
    logic [SEL_W-1:0] sel_v;
    for (int s = 0; s < 2; s++) begin
      haz_v = 1'b0;
      sel_v = '0;
      // Walk oldest to youngest so a younger match overwrites an older one
      for (int k = NUM_STAGES - 1; k >= 0; k--) begin
        if (src_use_s[s] && (src_rs_s[s] != '0) && entry_r[k].valid &&
            entry_r[k].we && (entry_r[k].rd == src_rs_s[s])) begin
          if (FWD_EN != 0) begin
            haz_v = (SEL_W'(k) < entry_r[k].rdy_stage);
            sel_v = haz_v ? '0 : SEL_W'(k + 1);
          end else begin
            haz_v = 1'b1;
            sel_v = '0;
          end
        end else begin
          haz_v = haz_v;
          sel_v = sel_v;
        end
      end
      src_haz_s[s] = haz_v;
      src_sel_s[s] = sel_v;
    end
  end

  // Decode handshake: stall on any unresolved hazard or a busy EXE unit
  always_comb begin
    stall_s       = src_haz_s[0] | src_haz_s[1] | bus.exe_stall_i;
    fire_s        = bus.issue_valid_i & ~stall_s & ~bus.flush_i;
    hold_s        = bus.exe_stall_i & ~bus.flush_i;
    issue_entry_s = {1'b1, bus.issue_rd_i, bus.issue_we_i, bus.issue_rdy_stage_i};
  end

  // Next pipeline contents: shift, EXE hold with bubble, then flush kill
  always_comb begin
    if (hold_s) begin
      entry_nxt_s[0] = entry_r[0];
    end else begin
      entry_nxt_s[0] = fire_s ? issue_entry_s : BUBBLE;
    end
    for (int k = 1; k < NUM_STAGES; k++) begin
      entry_nxt_s[k] = (hold_s && (k == 1)) ? BUBBLE : entry_r[k-1];
    end
    for (int j = 0; j < NUM_STAGES; j++) begin
      entry_nxt_s[j].valid = entry_nxt_s[j].valid & ~(bus.flush_i & (j < FLUSH_DEPTH));
    end
  end

  // Pipeline entry registers; the last stage simply falls off the end
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        entry_r[k] <= BUBBLE;
      end
    end else begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        entry_r[k] <= entry_nxt_s[k];
      end
    end
  end

  // Saturating count of stalled decode cycles
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      stall_cnt_r <= 32'd0;
    end else if (stall_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  // Drive the bus outputs
  always_comb begin
    bus.stall_o       = stall_s;
    bus.issue_fire_o  = fire_s;
    bus.fwd_rs1_sel_o = src_sel_s[0];
    bus.fwd_rs2_sel_o = src_sel_s[1];
    bus.stall_cnt_o   = stall_cnt_r;
    for (int k = 0; k < NUM_STAGES; k++) begin
      bus.stage_valid_o[k] = entry_r[k].valid;
    end
  end

endmodule
